// File: rtl/tft_spi_arbiter_pkg.sv
// Shared display package: requester indices, default sizing and arbiter state encoding.
package tft_spi_arbiter_pkg;

    localparam int unsigned NUM_REQ_DEF = 3;

    localparam int unsigned REQ_INIT   = 0;
    localparam int unsigned REQ_SCENE  = 1;
    localparam int unsigned REQ_PLAYER = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

endpackage

// File: rtl/tft_spi_arbiter_rr_pick.sv
// Round-robin winner search over requesters 1..NUM_REQ-1, starting at rr_ptr_i.
module tft_spi_arbiter_rr_pick
    import tft_spi_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] pick_o
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // First requesting index at or after the pointer, wrapping from NUM_REQ-1 back to 1.
    always_comb begin
        pick_o = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned off = 0; off < NUM_REQ - 1; off++) begin
            idx = PTR_W'(((32'(rr_ptr_i) - 32'd1 + off) % (NUM_REQ - 1)) + 1);
            if (!found && req_i[idx]) begin
                pick_o[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tft_spi_arbiter.sv
// Arbitrates several byte producers onto one SPI transmitter: fixed-priority init
// requester, round-robin for the rest, and a drain window before releasing the bus.
module tft_spi_arbiter
    import tft_spi_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
    parameter int unsigned DRAIN_IDLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_dc,
    input  logic [NUM_REQ-1:0]   req_transmit,
    input  logic                 spi_busy,
    output logic [7:0]           spi_data,
    output logic                 spi_dc,
    output logic                 spi_transmit,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 bus_busy,
    output logic                 err_drop
);

    localparam int unsigned PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (DRAIN_IDLE > 1) ? $clog2(DRAIN_IDLE + 1) : 1;

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [NUM_REQ-1:0] rr_win;
    logic [NUM_REQ-1:0] win_c;
    logic               drop_c;

    tft_spi_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .pick_o   (rr_win)
    );

    // Init requester beats the round-robin pick outright.
    assign win_c  = req[REQ_INIT] ? NUM_REQ'(1) : rr_win;
    assign drop_c = |(req_transmit & ~grant_q);

    // Zero-latency forward of the owner's slice; nothing passes without a grant.
    always_comb begin
        spi_data     = '0;
        spi_dc       = 1'b0;
        spi_transmit = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                spi_data     = spi_data | req_data[8*i +: 8];
                spi_dc       = spi_dc | req_dc[i];
                spi_transmit = spi_transmit | req_transmit[i];
            end
        end
    end

    // Next-state logic for ownership, round-robin pointer, drain counter and error flag.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q | drop_c;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                cnt_d   = '0;
                if (|req) begin
                    state_d = ST_OWN;
                    grant_d = win_c;
                    if (!req[REQ_INIT]) begin
                        for (int unsigned k = 1; k < NUM_REQ; k++) begin
                            if (rr_win[k]) begin
                                rr_ptr_d = (k == NUM_REQ - 1) ? PTR_W'(REQ_SCENE) : PTR_W'(k + 1);
                            end
                        end
                    end
                end
            end
            ST_OWN: begin
                if (!(|(req & grant_q))) begin
                    state_d = ST_DRAIN;
                    grant_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                grant_d = '0;
                if (spi_busy) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(DRAIN_IDLE - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset abandons any transaction immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= PTR_W'(REQ_SCENE);
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign grant    = grant_q;
    assign bus_busy = (state_q != ST_IDLE);
    assign err_drop = err_q;

endmodule

// File: tb/tb_tft_spi_arbiter.sv
// Scoreboarded bench for tft_spi_arbiter: expected grants queued with stimulus,
// popped by a monitor whenever a new grant appears.
module tb_tft_spi_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned DI = 2;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_dc;
    logic [N-1:0]   req_transmit;
    logic           spi_busy;
    logic [7:0]     spi_data;
    logic           spi_dc;
    logic           spi_transmit;
    logic [N-1:0]   grant;
    logic           bus_busy;
    logic           err_drop;

    int n_tests = 0;
    int n_fail  = 0;

    logic [N-1:0] exp_q[$];
    logic [N-1:0] prev_grant = '0;

    tft_spi_arbiter #(.NUM_REQ(N), .DRAIN_IDLE(DI)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .req_dc       (req_dc),
        .req_transmit (req_transmit),
        .spi_busy     (spi_busy),
        .spi_data     (spi_data),
        .spi_dc       (spi_dc),
        .spi_transmit (spi_transmit),
        .grant        (grant),
        .bus_busy     (bus_busy),
        .err_drop     (err_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string tag, input logic [N-1:0] exp);
        for (int i = 0; i < 40; i++) begin
            if (grant === exp) break;
            @(negedge clk);
        end
        check_eq(tag, 32'(grant), 32'(exp));
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (bus_busy === 1'b0) break;
            @(negedge clk);
        end
        check_eq(tag, 32'(bus_busy), 32'd0);
    endtask

    // Scoreboard monitor: every fresh grant must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && grant != '0 && prev_grant == '0) begin
            if (exp_q.size() == 0) check_eq("sb_unexpected", 32'(grant), 32'd0);
            else check_eq("sb_grant", 32'(grant), 32'(exp_q.pop_front()));
        end
        prev_grant <= grant;
    end

    initial begin
        int drain_cycles;
        rst = 1'b1; req = '0; req_data = '0; req_dc = '0; req_transmit = '0; spi_busy = 1'b0;

        // Reset values, no clock edge yet
        #3;
        check_eq("rst_grant",    32'(grant),        32'd0);
        check_eq("rst_bus_busy", 32'(bus_busy),     32'd0);
        check_eq("rst_transmit", 32'(spi_transmit), 32'd0);
        check_eq("rst_data",     32'(spi_data),     32'd0);
        check_eq("rst_dc",       32'(spi_dc),       32'd0);
        check_eq("rst_err",      32'(err_drop),     32'd0);
        cyc(); cyc();
        rst = 1'b0;

        // Round robin from pointer 1, then index 2 after drain
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b100);
        cyc();
        req = 3'b110;
        @(negedge clk);
        check_eq("lat_before_edge", 32'(grant), 32'd0);
        @(negedge clk);
        check_eq("lat_one_cycle", 32'(grant), 32'b010);
        cyc();
        req_data = 24'h00A500; req_dc = 3'b010; req_transmit = 3'b010;
        #1;
        check_eq("fwd_data",     32'(spi_data),     32'hA5);
        check_eq("fwd_dc",       32'(spi_dc),       32'd1);
        check_eq("fwd_transmit", 32'(spi_transmit), 32'd1);
        check_eq("own_bus_busy", 32'(bus_busy),     32'd1);
        cyc();
        req_transmit = 3'b100;
        #1;
        check_eq("mask_transmit", 32'(spi_transmit), 32'd0);
        cyc();
        req_transmit = '0;
        #1;
        check_eq("err_set", 32'(err_drop), 32'd1);
        // Final strobe in the same cycle the owner drops req
        req = 3'b100; req_transmit = 3'b010;
        #1;
        check_eq("last_strobe", 32'(spi_transmit), 32'd1);
        cyc();
        req_transmit = '0;
        #1;
        check_eq("drain_grant",    32'(grant),    32'd0);
        check_eq("drain_bus_busy", 32'(bus_busy), 32'd1);
        wait_grant("rr_next", 3'b100);

        // Owner is never preempted by index 0
        cyc();
        req = 3'b101;
        cyc(); cyc(); cyc();
        check_eq("no_preempt", 32'(grant), 32'b100);
        exp_q.push_back(3'b001);
        req = 3'b001;
        wait_grant("init_after", 3'b001);

        // Drain with spi_busy high for 10 cycles; requester 1 waits meanwhile
        exp_q.push_back(3'b010);
        cyc();
        spi_busy = 1'b1; req = 3'b010;
        drain_cycles = 0;
        fork
            begin
                @(negedge clk);
                for (int i = 0; i < 60; i++) begin
                    @(negedge clk);
                    if (bus_busy && grant == '0) drain_cycles++;
                    if (grant != '0) break;
                end
            end
            begin
                repeat (11) cyc();
                spi_busy = 1'b0;
            end
        join
        check_eq("drain_len",   32'(drain_cycles), 32'(10 + DI));
        check_eq("drain_grant", 32'(grant),        32'b010);
        req = '0;
        wait_idle("idle_a");

        // Index 0 and both round-robin requesters together; pointer is 2 here
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b010);
        cyc();
        req = 3'b111;
        wait_grant("prio_init", 3'b001);
        cyc();
        req = 3'b110;
        wait_grant("keep_turn", 3'b100);
        cyc();
        req = 3'b010;
        wait_grant("rr_wrap", 3'b010);
        cyc();
        req = '0;
        wait_idle("idle_b");

        // Asynchronous reset mid-OWN with a live strobe
        exp_q.push_back(3'b010);
        cyc();
        req = 3'b010;
        wait_grant("pre_rst_grant", 3'b010);
        check_eq("err_sticky", 32'(err_drop), 32'd1);
        cyc();
        req_transmit = 3'b010;
        #1;
        check_eq("pre_rst_strobe", 32'(spi_transmit), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_grant",    32'(grant),        32'd0);
        check_eq("arst_bus_busy", 32'(bus_busy),     32'd0);
        check_eq("arst_transmit", 32'(spi_transmit), 32'd0);
        check_eq("arst_data",     32'(spi_data),     32'd0);
        check_eq("arst_err",      32'(err_drop),     32'd0);
        req = '0; req_transmit = '0;
        cyc();
        rst = 1'b0;
        cyc();
        check_eq("post_rst_grant", 32'(grant), 32'd0);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
